turn_controller: RTL and testbench

Sequences one Battleship game round by round: accepts the player's committed shot, resolves it against the PC fleet map, generates and resolves the PC's counter-shot, and enforces the per-turn time limit. Sits between the coordinate selectors and select-button conditioning on one side and the game state machine and seven-segment counters on the other. It owns both shot maps, both boats-left counters and the PC's pseudo-random targeting.

---
 rtl/battleship_pkg.sv | 37 +++
 rtl/battleship_lfsr.sv | 30 +++
 rtl/turn_controller.sv | 255 +++++++++++++++++++++++++
 tb/tb_turn_controller.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/battleship_pkg.sv
// Shared types, board geometry, LFSR constants and coordinate helpers for the
// Battleship turn sequencer.
package battleship_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PLAYER_WAIT,
        ST_PLAYER_RESOLVE,
        ST_PC_PICK,
        ST_PC_RESOLVE,
        ST_WIN,
        ST_LOSE
    } state_t;

    localparam int BOARD_N = 5;
    localparam int CELLS   = BOARD_N * BOARD_N;

    // Seed is non-zero so the LFSR never locks up in the all-zero state.
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // x^8 + x^6 + x^5 + x^4 + 1 as register bit positions 7, 5, 4, 3.
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    // Flat cell index used by the fleet and shot bitmaps: row*5 + col.
    function automatic logic [4:0] coord_to_idx(input logic [2:0] row,
                                                input logic [2:0] col);
        return 5'(int'(row) * BOARD_N + int'(col));
    endfunction

    function automatic logic [2:0] idx_to_row(input logic [4:0] idx);
        return 3'(int'(idx) / BOARD_N);
    endfunction

    function automatic logic [2:0] idx_to_col(input logic [4:0] idx);
        return 3'(int'(idx) % BOARD_N);
    endfunction

endpackage

// File: rtl/battleship_lfsr.sv
// Free-running 8-bit maximal-length Fibonacci LFSR used for PC targeting.
// Runs every cycle regardless of game state so the PC's picks depend on
// how long the player took.
module battleship_lfsr
    import battleship_pkg::*;
(
    input  logic       clk,
    input  logic       rstSwitch,
    output logic [7:0] value
);

    logic feedback;

    // Feedback is the XOR of the tapped bits.
    always_comb begin
        feedback = ^(value & LFSR_TAPS);
    end

    // Shift left one position per clock, feedback entering at bit 0.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (rstSwitch) begin
            value <= LFSR_SEED;
        end else begin
            value <= {value[6:0], feedback};
        end
    end

endmodule

// File: rtl/turn_controller.sv
// Turn sequencer for one Battleship game: player shot, PC counter-shot,
// turn timeout, shot maps, boats-left counters and win/lose detection.
module turn_controller
    import battleship_pkg::*;
#(
    parameter int TURN_CYCLES = 50_000_000,
    parameter int NUM_BOATS   = 5
) (
    input  logic             clk,
    input  logic             rstSwitch,
    input  logic             initGame,
    input  logic             selectPulse,
    input  logic [2:0]       rowCoord,
    input  logic [2:0]       colCoord,
    input  logic [CELLS-1:0] pcShipMap,
    input  logic [CELLS-1:0] playerShipMap,
    output logic [2:0]       pcBoats,
    output logic [2:0]       playerBoats,
    output logic             playState,
    output logic             pcState,
    output logic             playerMov,
    output logic             pcMov,
    output logic             lastHit,
    output logic [2:0]       pcRow,
    output logic [2:0]       pcCol,
    output logic             timeExpired,
    output logic             shotReject,
    output logic             playerWin,
    output logic             pcWin
);

    localparam logic [31:0] TIMER_LAST = 32'(TURN_CYCLES - 1);
    localparam logic [2:0]  BOATS_INIT = 3'(NUM_BOATS);

    // ---------------------------------------------------------------- state
    state_t           state_q, state_d;
    logic [31:0]      timer_q, timer_d;
    logic [CELLS-1:0] player_shots_q, player_shots_d;  // cells the player fired at
    logic [CELLS-1:0] pc_shots_q, pc_shots_d;          // cells the PC fired at
    logic [2:0]       pc_boats_q, pc_boats_d;
    logic [2:0]       player_boats_q, player_boats_d;
    logic [4:0]       tgt_idx_q, tgt_idx_d;            // latched player target
    logic [4:0]       pc_idx_q, pc_idx_d;              // latched PC target
    logic             last_hit_q, last_hit_d;
    logic [2:0]       pc_row_q, pc_row_d;
    logic [2:0]       pc_col_q, pc_col_d;
    logic             player_mov_q, player_mov_d;
    logic             pc_mov_q, pc_mov_d;
    logic             time_expired_q, time_expired_d;
    logic             shot_reject_q, shot_reject_d;
    logic             play_state_q, play_state_d;
    logic             pc_state_q, pc_state_d;
    logic             player_win_q, player_win_d;
    logic             pc_win_q, pc_win_d;

    // ------------------------------------------------------------- helpers
    logic [7:0] lfsr_value;
    logic       lfsr_unused;
    logic [4:0] sel_idx;
    logic       sel_in_range;
    logic       sel_cell_shot;
    logic       sel_valid;
    logic [4:0] pc_cand;
    logic       pc_cand_ok;
    logic       resolve_hit;
    logic       pc_dec;
    logic       player_dec;

    battleship_lfsr u_lfsr (
        .clk       (clk),
        .rstSwitch (rstSwitch),
        .value     (lfsr_value)
    );

    // Only the low five bits address the board; the rest just feed the shift.
    assign lfsr_unused = &{1'b0, lfsr_value[7:5]};

    // Qualify the player's select and the PC's candidate cell.
    always_comb begin
        sel_idx       = coord_to_idx(rowCoord, colCoord);
        sel_in_range  = (rowCoord < 3'(BOARD_N)) && (colCoord < 3'(BOARD_N));
        // Out-of-range coordinates are treated as an already-shot cell.
        sel_cell_shot = sel_in_range ? player_shots_q[sel_idx] : 1'b1;
        sel_valid     = selectPulse && !sel_cell_shot;
        pc_cand       = lfsr_value[4:0];
        pc_cand_ok    = (pc_cand < 5'(CELLS)) && !pc_shots_q[pc_cand];
    end

    // Next-state, datapath and registered-output logic for the turn FSM.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d        = state_q;
        timer_d        = timer_q;
        player_shots_d = player_shots_q;
        pc_shots_d     = pc_shots_q;
        pc_boats_d     = pc_boats_q;
        player_boats_d = player_boats_q;
        tgt_idx_d      = tgt_idx_q;
        pc_idx_d       = pc_idx_q;
        last_hit_d     = last_hit_q;
        pc_row_d       = pc_row_q;
        pc_col_d       = pc_col_q;
        player_mov_d   = 1'b0;
        pc_mov_d       = 1'b0;
        time_expired_d = 1'b0;
        shot_reject_d  = 1'b0;
        resolve_hit    = 1'b0;
        pc_dec         = 1'b0;
        player_dec     = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_WIN, ST_LOSE: begin
                if (initGame) begin
                    pc_boats_d     = BOATS_INIT;
                    player_boats_d = BOATS_INIT;
                    player_shots_d = '0;
                    pc_shots_d     = '0;
                    timer_d        = '0;
                    state_d        = ST_PLAYER_WAIT;
                end
            end

            ST_PLAYER_WAIT: begin
                timer_d = timer_q + 32'd1;
                // A valid select beats a same-cycle timeout; an invalid one
                // loses to it and is not reported as a reject.
                if (sel_valid) begin
                    tgt_idx_d = sel_idx;
                    state_d   = ST_PLAYER_RESOLVE;
                end else if (timer_q == TIMER_LAST) begin
                    time_expired_d = 1'b1;
                    state_d        = ST_PC_PICK;
                end else if (selectPulse) begin
                    shot_reject_d = 1'b1;
                end
            end

            ST_PLAYER_RESOLVE: begin
                player_shots_d[tgt_idx_q] = 1'b1;
                resolve_hit               = pcShipMap[tgt_idx_q];
                last_hit_d                = resolve_hit;
                player_mov_d              = 1'b1;
                if (resolve_hit) begin
                    pc_dec     = 1'b1;
                    pc_boats_d = pc_boats_q - 3'd1;
                end
                state_d = (pc_boats_d == 3'd0) ? ST_WIN : ST_PC_PICK;
            end

            ST_PC_PICK: begin
                // Unusable candidates are simply retried with the next LFSR value.
                if (pc_cand_ok) begin
                    pc_idx_d = pc_cand;
                    state_d  = ST_PC_RESOLVE;
                end
            end

            ST_PC_RESOLVE: begin
                pc_shots_d[pc_idx_q] = 1'b1;
                pc_row_d             = idx_to_row(pc_idx_q);
                pc_col_d             = idx_to_col(pc_idx_q);
                resolve_hit          = playerShipMap[pc_idx_q];
                last_hit_d           = resolve_hit;
                pc_mov_d             = 1'b1;
                timer_d              = '0;
                if (resolve_hit) begin
                    player_dec     = 1'b1;
                    player_boats_d = player_boats_q - 3'd1;
                end
                state_d = (player_boats_d == 3'd0) ? ST_LOSE : ST_PLAYER_WAIT;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Level status flags reflect the state being entered, so they are
        // registered together with it.
        play_state_d = (state_d == ST_PLAYER_WAIT);
        pc_state_d   = (state_d == ST_PC_PICK) || (state_d == ST_PC_RESOLVE);
        player_win_d = (state_d == ST_WIN);
        pc_win_d     = (state_d == ST_LOSE);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rstSwitch) begin
            state_q        <= ST_IDLE;
            timer_q        <= '0;
            // NOTE: the shot maps are plain flop vectors, not RAM, so clearing
            // them in reset is cheap and keeps a fresh game from seeing stale shots.
            player_shots_q <= '0;
            pc_shots_q     <= '0;
            pc_boats_q     <= '0;
            player_boats_q <= '0;
            tgt_idx_q      <= '0;
            pc_idx_q       <= '0;
            last_hit_q     <= 1'b0;
            pc_row_q       <= '0;
            pc_col_q       <= '0;
            player_mov_q   <= 1'b0;
            pc_mov_q       <= 1'b0;
            time_expired_q <= 1'b0;
            shot_reject_q  <= 1'b0;
            play_state_q   <= 1'b0;
            pc_state_q     <= 1'b0;
            player_win_q   <= 1'b0;
            pc_win_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            player_shots_q <= player_shots_d;
            pc_shots_q     <= pc_shots_d;
            pc_boats_q     <= pc_boats_d;
            player_boats_q <= player_boats_d;
            tgt_idx_q      <= tgt_idx_d;
            pc_idx_q       <= pc_idx_d;
            last_hit_q     <= last_hit_d;
            pc_row_q       <= pc_row_d;
            pc_col_q       <= pc_col_d;
            player_mov_q   <= player_mov_d;
            pc_mov_q       <= pc_mov_d;
            time_expired_q <= time_expired_d;
            shot_reject_q  <= shot_reject_d;
            play_state_q   <= play_state_d;
            pc_state_q     <= pc_state_d;
            player_win_q   <= player_win_d;
            pc_win_q       <= pc_win_d;
        end
    end

    // A hit is only possible on a live boat, so a counter at zero is never
    // decremented; this guards the fleet-map preconditions.
    assert property (@(posedge clk) disable iff (rstSwitch)
                     !(pc_dec && pc_boats_q == 3'd0));
    assert property (@(posedge clk) disable iff (rstSwitch)
                     !(player_dec && player_boats_q == 3'd0));

    assign pcBoats     = pc_boats_q;
    assign playerBoats = player_boats_q;
    assign playState   = play_state_q;
    assign pcState     = pc_state_q;
    assign playerMov   = player_mov_q;
    assign pcMov       = pc_mov_q;
    assign lastHit     = last_hit_q;
    assign pcRow       = pc_row_q;
    assign pcCol       = pc_col_q;
    assign timeExpired = time_expired_q;
    assign shotReject  = shot_reject_q;
    assign playerWin   = player_win_q;
    assign pcWin       = pc_win_q;

endmodule

// File: tb/tb_turn_controller.sv
// Directed bench for turn_controller: three games covering player hits,
// rejects, timeout boundaries, player win, PC win and mid-turn reset.
module tb_turn_controller;

    localparam int TC = 20;

    localparam logic [24:0] PC_MAP = (25'd1 << 0) | (25'd1 << 7) | (25'd1 << 12) |
                                     (25'd1 << 18) | (25'd1 << 24);
    localparam logic [24:0] PL_MAP = (25'd1 << 1) | (25'd1 << 3) | (25'd1 << 10) |
                                     (25'd1 << 20) | (25'd1 << 22);

    logic        clk = 1'b0;
    logic        rstSwitch;
    logic        initGame;
    logic        selectPulse;
    logic [2:0]  rowCoord;
    logic [2:0]  colCoord;
    logic [24:0] pcShipMap;
    logic [24:0] playerShipMap;
    logic [2:0]  pcBoats;
    logic [2:0]  playerBoats;
    logic        playState;
    logic        pcState;
    logic        playerMov;
    logic        pcMov;
    logic        lastHit;
    logic [2:0]  pcRow;
    logic [2:0]  pcCol;
    logic        timeExpired;
    logic        shotReject;
    logic        playerWin;
    logic        pcWin;

    int          checks = 0;
    int          errors = 0;
    int          t = 0;          // cycles since PLAYER_WAIT was entered
    int          exp_pb = 0;     // expected player boats
    int          pc_shots = 0;
    logic [24:0] seen = '0;      // PC shots this game

    turn_controller #(
        .TURN_CYCLES (TC),
        .NUM_BOATS   (5)
    ) dut (
        .clk           (clk),
        .rstSwitch     (rstSwitch),
        .initGame      (initGame),
        .selectPulse   (selectPulse),
        .rowCoord      (rowCoord),
        .colCoord      (colCoord),
        .pcShipMap     (pcShipMap),
        .playerShipMap (playerShipMap),
        .pcBoats       (pcBoats),
        .playerBoats   (playerBoats),
        .playState     (playState),
        .pcState       (pcState),
        .playerMov     (playerMov),
        .pcMov         (pcMov),
        .lastHit       (lastHit),
        .pcRow         (pcRow),
        .pcCol         (pcCol),
        .timeExpired   (timeExpired),
        .shotReject    (shotReject),
        .playerWin     (playerWin),
        .pcWin         (pcWin)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
        t++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic sel_cell(input int r, input int c);
        selectPulse = 1'b1;
        rowCoord    = 3'(r);
        colCoord    = 3'(c);
        step();
        selectPulse = 1'b0;
    endtask

    // Valid select now; resolve result appears one cycle later.
    task automatic player_shot(input int r, input int c, input int hit, input int pcb);
        sel_cell(r, c);
        check("player_mov_early", 32'(playerMov), 0);
        step();
        check("player_mov", 32'(playerMov), 1);
        check("player_last_hit", 32'(lastHit), 32'(hit));
        check("pc_boats", 32'(pcBoats), 32'(pcb));
    endtask

    task automatic wait_timeout(input int pcb);
        while (!timeExpired && t < 3 * TC) step();
        check("timeout_cycle", 32'(t), 32'(TC));
        check("timeout_pc_boats", 32'(pcBoats), 32'(pcb));
        check("timeout_pc_state", 32'(pcState), 1);
    endtask

    // Waits for the PC shot and checks it against the player's fleet map.
    task automatic wait_pc_shot();
        int n = 0;
        int idx;
        do begin
            step();
            n++;
        end while (!pcMov && n < 300);
        check("pc_latency_ok", 32'(n >= 2 && n <= 256), 1);
        if (pcMov) begin
            idx = int'(pcRow) * 5 + int'(pcCol);
            check("pc_coord_range", 32'(pcRow < 3'd5 && pcCol < 3'd5), 1);
            if (idx < 25) begin
                check("pc_no_repeat", 32'(seen[idx]), 0);
                seen[idx] = 1'b1;
                if (PL_MAP[idx]) exp_pb--;
                check("pc_last_hit", 32'(lastHit), 32'(PL_MAP[idx]));
            end
            pc_shots++;
            check("player_boats", 32'(playerBoats), 32'(exp_pb));
            check("pc_win", 32'(pcWin), 32'(exp_pb == 0));
            check("play_state_after_pc", 32'(playState), 32'(exp_pb != 0));
        end
        t = 0;
    endtask

    initial begin
        rstSwitch     = 1'b1;
        initGame      = 1'b0;
        selectPulse   = 1'b0;
        rowCoord      = 3'd0;
        colCoord      = 3'd0;
        pcShipMap     = PC_MAP;
        playerShipMap = PL_MAP;

        // Reset values
        step();
        step();
        check("rst_pc_boats", 32'(pcBoats), 0);
        check("rst_player_boats", 32'(playerBoats), 0);
        check("rst_play_state", 32'(playState), 0);
        check("rst_pc_state", 32'(pcState), 0);
        check("rst_pulses", 32'({playerMov, pcMov, timeExpired, shotReject}), 0);
        check("rst_wins", 32'({playerWin, pcWin, lastHit}), 0);
        rstSwitch = 1'b0;
        step();
        check("idle_play_state", 32'(playState), 0);

        // ---------------- Game 1: player wins
        initGame = 1'b1;
        step();
        initGame = 1'b0;
        t = 0;
        exp_pb = 5;
        seen = '0;
        check("init_pc_boats", 32'(pcBoats), 5);
        check("init_player_boats", 32'(playerBoats), 5);
        check("init_play_state", 32'(playState), 1);
        check("init_pulses", 32'({playerMov, pcMov, timeExpired, shotReject}), 0);

        player_shot(1, 2, 1, 4);
        check("pc_state_after_player", 32'(pcState), 1);
        check("play_state_after_player", 32'(playState), 0);
        wait_pc_shot();

        sel_cell(1, 2);
        check("reject_repeat", 32'(shotReject), 1);
        check("reject_stays_wait", 32'(playState), 1);
        step();
        check("reject_one_cycle", 32'(shotReject), 0);
        sel_cell(5, 0);
        check("reject_row", 32'(shotReject), 1);
        sel_cell(2, 6);
        check("reject_col", 32'(shotReject), 1);
        check("reject_no_mov", 32'(playerMov), 0);
        player_shot(0, 0, 1, 3);
        wait_pc_shot();

        // Valid select sampled on the timeout edge wins
        while (t < TC - 1) step();
        sel_cell(2, 2);
        check("sel_beats_timeout", 32'(timeExpired), 0);
        check("sel_beats_timeout_state", 32'(playState), 0);
        step();
        check("edge_sel_mov", 32'(playerMov), 1);
        check("edge_sel_pc_boats", 32'(pcBoats), 2);
        wait_pc_shot();

        player_shot(3, 3, 1, 1);
        wait_pc_shot();
        player_shot(4, 4, 1, 0);
        check("player_win", 32'(playerWin), 1);
        check("win_pc_state", 32'(pcState), 0);

        sel_cell(0, 1);
        check("win_select_no_reject", 32'(shotReject), 0);
        step();
        check("win_select_no_mov", 32'(playerMov), 0);
        check("win_holds", 32'({playerWin, pcBoats}), 32'({1'b1, 3'd0}));

        // ---------------- Game 2: PC wins, player never hits
        initGame = 1'b1;
        step();
        initGame = 1'b0;
        t = 0;
        exp_pb = 5;
        pc_shots = 0;
        seen = '0;
        check("restart_pc_boats", 32'(pcBoats), 5);
        check("restart_player_boats", 32'(playerBoats), 5);
        check("restart_player_win", 32'(playerWin), 0);
        check("restart_play_state", 32'(playState), 1);

        player_shot(0, 1, 0, 5);
        wait_pc_shot();

        // Invalid select on the timeout edge loses; only timeExpired pulses
        while (t < TC - 1) step();
        sel_cell(0, 1);
        check("timeout_beats_bad_sel", 32'(timeExpired), 1);
        check("timeout_no_reject", 32'(shotReject), 0);
        wait_pc_shot();

        while (exp_pb > 0 && pc_shots < 25) begin
            wait_timeout(5);
            wait_pc_shot();
        end
        check("pc_win_final", 32'(pcWin), 1);
        check("lose_player_boats", 32'(playerBoats), 0);
        check("lose_pc_state", 32'(pcState), 0);

        // ---------------- Game 3: reset during PC_PICK
        initGame = 1'b1;
        step();
        initGame = 1'b0;
        t = 0;
        wait_timeout(5);
        rstSwitch = 1'b1;
        step();
        rstSwitch = 1'b0;
        check("abort_states", 32'({playState, pcState, pcWin, playerWin}), 0);
        check("abort_counters", 32'({pcBoats, playerBoats}), 0);
        check("abort_pc_coords", 32'({pcRow, pcCol, lastHit}), 0);
        check("abort_pulses", 32'({playerMov, pcMov, timeExpired, shotReject}), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
